// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and baud helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_ACK
  } uart_tx_state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: free-running bit timer, ticks on the last clock of each bit time
module uart_baud_timer #(
  parameter int BIT_CYCLES = 10
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(BIT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(BIT_CYCLES - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with runtime parity/stop selection and Send/Sent handshake
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 19_200,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Send,
  input  logic [DATA_BITS-1:0] Din,
  input  logic [1:0]           Parity,
  input  logic                 StopTwo,
  output logic                 Sout,
  output logic                 Sent,
  output logic                 Busy
);
  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ_HZ, BAUD);
  localparam int IW = $clog2(DATA_BITS);
  uart_tx_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0] par_q, par_d;
  logic stop_q, stop_d, two_q, two_d, sout_q, sout_d, tick, par_bit;
  uart_baud_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk (clk),
    .clr (Reset || state_q == S_IDLE),
    .tick(tick)
  );
  assign par_bit = par_q == PAR_ODD ? ~^data_q : par_q == PAR_EVEN ? ^data_q : 1'b1;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    par_d   = par_q;
    two_d   = two_q;
    case (state_q)
      S_IDLE: if (Send) begin
        state_d = S_START;
        data_d  = Din;
        par_d   = Parity;
        two_d   = StopTwo;
      end
      S_START: if (tick) begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA: if (tick) begin
        idx_d   = idx_q == IW'(DATA_BITS - 1) ? idx_q : idx_q + 1'b1;
        stop_d  = 1'b0;
        state_d = idx_q != IW'(DATA_BITS - 1) ? S_DATA : par_q != PAR_NONE ? S_PAR : S_STOP;
      end
      S_PAR: if (tick) begin
        state_d = S_STOP;
        stop_d  = 1'b0;
      end
      S_STOP: if (tick) begin
        stop_d  = 1'b1;
        state_d = (two_q && !stop_q) ? S_STOP : S_ACK;
      end
      S_ACK: state_d = Send ? S_ACK : S_IDLE;
      default: state_d = uart_tx_state_t'('x);
    endcase
    // Sout is registered, so it is driven from the state being entered
    sout_d = state_d == S_START ? 1'b0 :
             state_d == S_DATA  ? data_q[idx_d] :
             state_d == S_PAR   ? par_bit : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= PAR_NONE;
      two_q   <= 1'b0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      par_q   <= par_d;
      two_q   <= two_d;
      sout_q  <= sout_d;
    end
  end
  assign Sout = sout_q;
  assign Sent = state_q == S_ACK;
  assign Busy = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed and randomized frames checked against a bit-list frame model
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic reset, send, sel, stoptwo;
  logic [8:0] din;
  logic [1:0] parity;
  logic sout8, sent8, busy8, sout7, sent7, busy7;
  logic sout, sent, busy;
  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  always #5 clk = ~clk;
  uart_tx_cfg #(.CLK_FREQ_HZ(1000), .BAUD(100), .DATA_BITS(8)) d8 (
    .clk(clk), .Reset(reset), .Send(send && !sel), .Din(din[7:0]), .Parity(parity),
    .StopTwo(stoptwo), .Sout(sout8), .Sent(sent8), .Busy(busy8));
  uart_tx_cfg #(.CLK_FREQ_HZ(1000), .BAUD(100), .DATA_BITS(7)) d7 (
    .clk(clk), .Reset(reset), .Send(send && sel), .Din(din[6:0]), .Parity(parity),
    .StopTwo(stoptwo), .Sout(sout7), .Sent(sent7), .Busy(busy7));
  assign sout = sel ? sout7 : sout8;
  assign sent = sel ? sent7 : sent8;
  assign busy = sel ? busy7 : busy8;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask
  // Expected line bits: start, data LSB first, optional parity, one or two stops
  task automatic build(input logic [8:0] d, input logic [1:0] p, input logic t, input int db);
    int ones = 0;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p == 2'd1) exp_q.push_back(ones % 2 == 0);
    if (p == 2'd2) exp_q.push_back(ones % 2 == 1);
    if (p == 2'd3) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    if (t) exp_q.push_back(1'b1);
  endtask
  task automatic check_frame(input logic [8:0] d, input logic [1:0] p, input logic t, input int db,
                             input logic [8:0] md, input logic [1:0] mp, input logic mt);
    build(d, p, t, db);
    for (int k = 0; k < exp_q.size() * 10; k++) begin
      chk("sout_bit", sout, exp_q[k / 10]);
      chk("sent_low", sent, 1'b0);
      chk("busy_high", busy, 1'b1);
      if (k == 25) begin
        din = md;
        parity = mp;
        stoptwo = mt;
      end
      @(posedge clk);
      #1;
    end
    chk("sent_rise", sent, 1'b1);
    chk("sout_ack", sout, 1'b1);
  endtask
  task automatic send_frame(input logic [8:0] d, input logic [1:0] p, input logic t, input int db,
                            input logic [8:0] md, input logic [1:0] mp, input logic mt);
    @(negedge clk);
    din = d;
    parity = p;
    stoptwo = t;
    send = 1'b1;
    @(posedge clk);
    #1;
    check_frame(d, p, t, db, md, mp, mt);
  endtask
  task automatic release_send(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("hold_sent", sent, 1'b1);
      chk("hold_sout", sout, 1'b1);
      chk("hold_busy", busy, 1'b1);
      @(posedge clk);
      #1;
    end
    send = 1'b0;
    @(posedge clk);
    #1;
    chk("sent_fall", sent, 1'b0);
    chk("busy_fall", busy, 1'b0);
    chk("idle_sout", sout, 1'b1);
  endtask
  initial begin
    logic [8:0] rd, rm;
    logic [1:0] rp;
    logic rt;
    reset = 1'b1;
    send = 1'b0;
    sel = 1'b0;
    din = '0;
    parity = 2'd0;
    stoptwo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sout8", sout8, 1'b1);
    chk("rst_sent8", sent8, 1'b0);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_sout7", sout7, 1'b1);
    chk("rst_sent7", sent7, 1'b0);
    chk("rst_busy7", busy7, 1'b0);
    reset = 1'b0;
    send_frame(9'h055, 2'd0, 1'b0, 8, 9'h055, 2'd0, 1'b0);
    release_send(50);
    for (int m = 1; m < 4; m++) begin
      send_frame(9'h007, 2'(m), 1'b0, 8, 9'h007, 2'(m), 1'b0);
      release_send(2);
    end
    sel = 1'b1;
    send_frame(9'h041, 2'd2, 1'b1, 7, 9'h041, 2'd2, 1'b1);
    release_send(1);
    sel = 1'b0;
    send_frame(9'h0A5, 2'd1, 1'b0, 8, 9'h03C, 2'd0, 1'b1);
    release_send(0);
    @(negedge clk);
    din = 9'h05A;
    parity = 2'd1;
    stoptwo = 1'b0;
    send = 1'b1;
    @(posedge clk);
    repeat (43) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_sout", sout, 1'b1);
    chk("midrst_sent", sent, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_send_ignored", busy, 1'b0);
    end
    reset = 1'b0;
    din = 9'h0C3;
    parity = 2'd2;
    @(posedge clk);
    #1;
    check_frame(9'h0C3, 2'd2, 1'b0, 8, 9'h0C3, 2'd2, 1'b0);
    release_send(3);
    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom_range(0, 1));
      rd = 9'($urandom);
      rm = 9'($urandom);
      rp = 2'($urandom);
      rt = 1'($urandom);
      send_frame(rd, rp, rt, sel ? 7 : 8, rm, 2'($urandom), 1'($urandom));
      release_send(int'($urandom_range(0, 5)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
